// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED between three blink requesters.
// The winner's colour and count are latched at grant and blinked ON/OFF, then done pulses.
module rgb_led_arbiter #(
  parameter int HALF_PERIOD = 10000000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] color0,
  input  logic [2:0] color1,
  input  logic [2:0] color2,
  input  logic [3:0] count0,
  input  logic [3:0] count1,
  input  logic [3:0] count2,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       busy,
  output logic       redled,
  output logic       greenled,
  output logic       blueled
);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [1:0]       last;
  logic [1:0]       owner;
  logic [2:0]       job_color;
  logic [3:0]       remaining;
  logic [2:0]       led;

  logic [1:0]       pick;
  logic [2:0]       pick_onehot;
  logic [2:0]       pick_color;
  logic [3:0]       pick_count;

  // First set request bit scanning last+1, last+2, last+3 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(l) + k) % 3);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    pick       = rr_pick(req, last);
    pick_color = color0;
    pick_count = count0;
    case (pick)
      2'd1: begin
        pick_color = color1;
        pick_count = count1;
      end
      2'd2: begin
        pick_color = color2;
        pick_count = count2;
      end
      default: ;
    endcase
  end

  assign pick_onehot = 3'b001 << pick;
  assign {redled, greenled, blueled} = led;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      last      <= 2'd2;
      owner     <= 2'd0;
      job_color <= 3'b000;
      remaining <= 4'd0;
      grant     <= 3'b000;
      done      <= 3'b000;
      busy      <= 1'b0;
      led       <= 3'b000;
    end else begin
      done <= 3'b000;
      case (state)
        IDLE: begin
          timer <= '0;
          if (|req) begin
            owner     <= pick;
            grant     <= pick_onehot;
            job_color <= pick_color;
            remaining <= pick_count;
            busy      <= 1'b1;
            if (pick_count == 4'd0) begin
              state <= DONE;
              done  <= pick_onehot;
              led   <= 3'b000;
            end else begin
              state <= ON;
              led   <= pick_color;
            end
          end
        end

        ON, OFF: begin
          if (!req[owner]) begin
            // Owner withdrew: release silently, no done pulse.
            state <= IDLE;
            timer <= '0;
            grant <= 3'b000;
            busy  <= 1'b0;
            led   <= 3'b000;
            last  <= owner;
          end else if (timer != TIMER_LAST) begin
            timer <= timer + TIMER_ONE;
          end else begin
            timer <= '0;
            if (state == ON) begin
              state <= OFF;
              led   <= 3'b000;
            end else begin
              remaining <= remaining - 4'd1;
              if (remaining == 4'd1) begin
                state <= DONE;
                done  <= grant;
              end else begin
                state <= ON;
                led   <= job_color;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
          timer <= '0;
          grant <= 3'b000;
          busy  <= 1'b0;
          led   <= 3'b000;
          last  <= owner;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter: a job table plus hand sequences for
// reset, abort, latch stability and round-robin, all checked through a per-cycle scoreboard.
module tb_rgb_led_arbiter;

  localparam int HP    = 4;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] color0, color1, color2;
  logic [3:0] count0, count1, count2;
  logic [2:0] grant, done;
  logic       busy, redled, greenled, blueled;

  rgb_led_arbiter #(.HALF_PERIOD(HP), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .color0   (color0),
    .color1   (color1),
    .color2   (color2),
    .count0   (count0),
    .count1   (count1),
    .count2   (count2),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .redled   (redled),
    .greenled (greenled),
    .blueled  (blueled)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    logic [2:0] led;
  } obs_t;

  typedef struct {
    logic [2:0] req;
    logic [2:0] color;
    logic [3:0] count;
    int         owner;
  } vec_t;

  obs_t exp_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t observe();
    return '{grant: grant, done: done, busy: busy, led: {redled, greenled, blueled}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs of one complete job, starting with the grant edge.
  task automatic push_job(input int owner, input logic [2:0] col, input logic [3:0] cnt);
    logic [2:0] g;
    g = 3'b001 << owner;
    for (int b = 0; b < int'(cnt); b++) begin
      repeat (HP) exp_q.push_back('{grant: g, done: 3'b000, busy: 1'b1, led: col});
      repeat (HP) exp_q.push_back('{grant: g, done: 3'b000, busy: 1'b1, led: 3'b000});
    end
    exp_q.push_back('{grant: g, done: g, busy: 1'b1, led: 3'b000});
    exp_q.push_back('{grant: 3'b000, done: 3'b000, busy: 1'b0, led: 3'b000});
  endtask

  function automatic int job_len(input logic [3:0] cnt);
    return int'(cnt) * 2 * HP + 2;
  endfunction

  task automatic expect_cycles(input string name, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s[%0d]: scoreboard empty, got %h", name, i, 32'(observe()));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", name, i), 32'(observe()), 32'(e));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{req: 3'b001, color: 3'b100, count: 4'd2, owner: 0};
    vecs[1] = '{req: 3'b010, color: 3'b010, count: 4'd0, owner: 1};
    vecs[2] = '{req: 3'b100, color: 3'b011, count: 4'd1, owner: 2};
    vecs[3] = '{req: 3'b010, color: 3'b111, count: 4'd3, owner: 1};
    vecs[4] = '{req: 3'b100, color: 3'b101, count: 4'd0, owner: 2};
    vecs[5] = '{req: 3'b001, color: 3'b001, count: 4'd1, owner: 0};

    rst_n  = 1'b0;
    req    = 3'b000;
    color0 = 3'b000; color1 = 3'b000; color2 = 3'b000;
    count0 = 4'd0;   count1 = 4'd0;   count2 = 4'd0;
    #12;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_done",  32'(done),  32'h0);
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_leds",  32'({redled, greenled, blueled}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester jobs; non-owner ports carry decoy colour/count.
    foreach (vecs[i]) begin
      color0 = (vecs[i].owner == 0) ? vecs[i].color : ~vecs[i].color;
      color1 = (vecs[i].owner == 1) ? vecs[i].color : ~vecs[i].color;
      color2 = (vecs[i].owner == 2) ? vecs[i].color : ~vecs[i].color;
      count0 = (vecs[i].owner == 0) ? vecs[i].count : 4'd7;
      count1 = (vecs[i].owner == 1) ? vecs[i].count : 4'd7;
      count2 = (vecs[i].owner == 2) ? vecs[i].count : 4'd7;
      req    = vecs[i].req;
      push_job(vecs[i].owner, vecs[i].color, vecs[i].count);
      expect_cycles($sformatf("job%0d", i), job_len(vecs[i].count));
      req = 3'b000;
    end

    // Latch stability: colour/count changes and a non-owner toggle mid-job have no effect.
    color0 = 3'b100; count0 = 4'd2; req = 3'b001;
    push_job(0, 3'b100, 4'd2);
    expect_cycles("latch_a", 2);
    color0 = 3'b001; count0 = 4'd5; req = 3'b011;
    expect_cycles("latch_b", 3);
    req = 3'b001;
    expect_cycles("latch_c", job_len(4'd2) - 5);
    req = 3'b000;

    // Abort in OFF; pending 0 and 1 then compete with last=2, so 0 wins.
    color0 = 3'b101; count0 = 4'd1;
    color1 = 3'b110; count1 = 4'd1;
    color2 = 3'b011; count2 = 4'd3;
    req = 3'b100;
    repeat (HP) exp_q.push_back('{grant: 3'b100, done: 3'b000, busy: 1'b1, led: 3'b011});
    repeat (2)  exp_q.push_back('{grant: 3'b100, done: 3'b000, busy: 1'b1, led: 3'b000});
    expect_cycles("abort_run", HP + 2);
    req = 3'b011;
    exp_q.push_back('{grant: 3'b000, done: 3'b000, busy: 1'b0, led: 3'b000});
    push_job(0, 3'b101, 4'd1);
    expect_cycles("abort_after", 1 + job_len(4'd1));
    req = 3'b000;

    // Asynchronous reset in the middle of ON.
    color0 = 3'b110; count0 = 4'd3; req = 3'b001;
    tick(); tick(); tick();
    check("pre_reset_led", 32'({redled, greenled, blueled}), 32'h6);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'h0);
    check("async_done",  32'(done),  32'h0);
    check("async_busy",  32'(busy),  32'h0);
    check("async_leds",  32'({redled, greenled, blueled}), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_reset_grant", 32'(grant), 32'h1);
    check("post_reset_leds",  32'({redled, greenled, blueled}), 32'h6);
    check("post_reset_busy",  32'(busy), 32'h1);

    // Round-robin with all three held, starting from reset (last=2).
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    color0 = 3'b100; color1 = 3'b010; color2 = 3'b001;
    count0 = 4'd1;   count1 = 4'd1;   count2 = 4'd1;
    req = 3'b111;
    #2;
    rst_n = 1'b1;
    push_job(0, 3'b100, 4'd1);
    push_job(1, 3'b010, 4'd1);
    push_job(2, 3'b001, 4'd1);
    push_job(0, 3'b100, 4'd1);
    expect_cycles("rr", 4 * job_len(4'd1));
    req = 3'b000;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
